call_stopwatch: RTL and testbench
=================================

# call_stopwatch

Elapsed-time stopwatch for the telephony UI. It counts call duration upward in BCD minutes:seconds, from 00:00 to 99:59, and is the count-up counterpart of the countdown timer. It contains its own 1 Hz prescaler, and the call-control FSM drives it with start, stop and clear strobes. Its digit outputs feed the display driver directly; its one-cycle second pulse can serve as the `enable` tick for countdown timers.

## Interface
- `TICKS_PER_SEC`, default 27_000_000: clk cycles per counted second; must be ≥ 2.
- `clk  in  1`: system clock; all state updates on its rising edge.
- `sys_reset_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: level-sampled each cycle; begin or resume counting.
- `stop  in  1`: level-sampled; pause counting and hold the digits.
- `clear  in  1`: level-sampled; zero the digits and return to IDLE.
- `min_tens  out  4`: BCD minutes tens digit, 0–9.
- `min_ones  out  4`: BCD minutes ones digit, 0–9.
- `sec_tens  out  4`: BCD seconds tens digit, 0–5.
- `sec_ones  out  4`: BCD seconds ones digit, 0–9.
- `running  out  1`: high while in RUNNING.
- `saturated  out  1`: high while in SATURATED (display shows 99:59).
- `sec_pulse  out  1`: one-cycle pulse on each counted second.

## Operation
- **States:** IDLE, RUNNING, PAUSED, SATURATED.
- **Command priority when several are high in the same cycle:** `clear` > `stop` > `start`.
- **`clear` from any state:**
  - digits go to 00:00 and the prescaler to 0;
  - next state is IDLE.
- **IDLE:**
  - `start` → RUNNING, with the prescaler reset to 0;
  - `stop` is ignored.
- **RUNNING:**
  - the prescaler counts up once per cycle;
  - when the prescaler equals `TICKS_PER_SEC-1`, it wraps to 0, the time increments by one second and `sec_pulse` is asserted;
  - `stop` → PAUSED, and the prescaler holds its value;
  - `start` is ignored.
- **PAUSED:**
  - the digits and prescaler are frozen;
  - `start` → RUNNING, and the prescaler resumes from its held value, so fractional seconds are preserved.
- **Increment arithmetic (BCD ripple):**
  - `sec_ones` 9→0 carries into `sec_tens`;
  - `sec_tens` 5→0 carries into `min_ones`;
  - `min_ones` 9→0 carries into `min_tens`.
- **Saturation:**
  - when the increment would leave 99:59 (all four carries set), the digits stay at 99:59 and the next state is SATURATED;
  - `sec_pulse` still fires on that cycle.
- **SATURATED:**
  - the digits are frozen and the prescaler is held at 0;
  - `start` and `stop` are ignored;
  - only `clear` exits.
- **Digit range:** out-of-range BCD values are unreachable; there is no load path.

## Timing
- **Reset values:**
  - all digits 0, `running`=0, `saturated`=0, `sec_pulse`=0;
  - state is IDLE and the prescaler is 0.
- **Reset behaviour:**
  - assertion takes effect immediately, regardless of clk;
  - deassertion is synchronised externally;
  - reset mid-count discards all progress.
- **Registered outputs:** every output is registered. A command sampled at edge E is reflected in `running` / `saturated` / digits after E.
- **Start latency:** if `start` is sampled at E0 from IDLE, the first increment and `sec_pulse` occur at edge E0+`TICKS_PER_SEC`. Subsequent increments follow every `TICKS_PER_SEC` cycles while RUNNING.
- **`sec_pulse` alignment:**
  - it is high for exactly one cycle and changes on the same edge as the updated digits;
  - it is never high outside RUNNING, except on the saturating increment, where it is high for the cycle after the edge entering SATURATED.
- **`stop` on a wrap cycle:** if `stop` is sampled on the same edge where the prescaler is at `TICKS_PER_SEC-1`, stop wins. There is no increment, and the prescaler holds at `TICKS_PER_SEC-1`. After resume, the increment occurs on the first RUNNING edge.
- **`clear` on a wrap cycle:** `clear` sampled at the wrap edge suppresses both the increment and `sec_pulse`.
- **Held commands:**
  - a held `start` in RUNNING has no effect;
  - a held `clear` keeps the block in IDLE.

## Test plan
All scenarios use `TICKS_PER_SEC`=4.
- **Reset and first count:** pulse `sys_reset_n` low mid-cycle → all outputs 0 immediately. Then `start` for 1 cycle → `running`=1 next cycle, `sec_ones`=1 and `sec_pulse`=1 exactly 4 edges after start; after 40 RUNNING cycles the display reads 00:10.
- **BCD carry:** run 236 cycles from 00:00 → display 00:59 with no pulse pending. 4 more cycles → 01:00, and `sec_pulse` was high for one cycle.
- **Pause preserves fraction:** `start`; `stop` after 6 cycles (display 00:01, prescaler 2). Hold in PAUSED for 20 cycles → no change and no pulse. `start` → 00:02 exactly 2 RUNNING edges later.
- **Saturation:** run 24000 cycles → 99:59, `saturated`=1, `running`=0, final `sec_pulse` seen once. 100 further cycles with `start` toggling → unchanged. `clear` → 00:00 and IDLE.
- **Priority and simultaneity:**
  - `start`+`stop`+`clear` together in RUNNING → IDLE, 00:00;
  - `stop`+`start` in RUNNING → PAUSED;
  - `stop` on the wrap edge → no increment, then 1 edge after resume → +1 second.
- **Reset mid-operation:** assert `sys_reset_n` low at 12:34 while RUNNING → immediate 00:00, `running`=0. After release, with no `start`, the display stays at 00:00 for 50 cycles.

Source files
------------

// File: rtl/call_stopwatch_if.sv
// Command and display bundle between call control, the call stopwatch and the display driver.
// The stopwatch takes the slave side; call control takes the master side.
interface call_stopwatch_if;
   logic       start;
   logic       stop;
   logic       clear;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       saturated;
   logic       sec_pulse;

   modport master (
      output start, stop, clear,
      input  min_tens, min_ones, sec_tens, sec_ones, running, saturated, sec_pulse
   );

   modport slave (
      input  start, stop, clear,
      output min_tens, min_ones, sec_tens, sec_ones, running, saturated, sec_pulse
   );
endinterface

// File: rtl/call_stopwatch.sv
// Call-duration stopwatch: counts BCD mm:ss from 00:00 up to 99:59 using an internal
// per-second prescaler, driven by start/stop/clear strobes (clear > stop > start).
module call_stopwatch #(
   parameter int unsigned TICKS_PER_SEC = 27_000_000
) (
   input logic              clk,
   input logic              sys_reset_n,
   call_stopwatch_if.slave  bus
);
   localparam int unsigned PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_RUNNING   = 2'd1;
   localparam logic [1:0] S_PAUSED    = 2'd2;
   localparam logic [1:0] S_SATURATED = 2'd3;

   logic [1:0]    state, state_nx;
   logic [PW-1:0] presc, presc_nx;
   logic [3:0]    min_tens, min_ones, sec_tens, sec_ones;
   logic [3:0]    min_tens_nx, min_ones_nx, sec_tens_nx, sec_ones_nx;
   logic          pulse_nx;
   logic          running_q, saturated_q, sec_pulse_q;
   logic          c_so, c_st, c_mo, c_mt;

   // Ripple carries out of each digit; c_mt means the display is at 99:59.
   assign c_so = (sec_ones == 4'd9);
   assign c_st = c_so && (sec_tens == 4'd5);
   assign c_mo = c_st && (min_ones == 4'd9);
   assign c_mt = c_mo && (min_tens == 4'd9);

   // NOTE: every combinational output takes a default before any branch, so no path
   // through the case statement leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nx    = state;
      presc_nx    = presc;
      min_tens_nx = min_tens;
      min_ones_nx = min_ones;
      sec_tens_nx = sec_tens;
      sec_ones_nx = sec_ones;
      pulse_nx    = 1'b0;

      if (bus.clear) begin
         state_nx    = S_IDLE;
         presc_nx    = '0;
         min_tens_nx = 4'd0;
         min_ones_nx = 4'd0;
         sec_tens_nx = 4'd0;
         sec_ones_nx = 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state_nx = S_RUNNING;
                  presc_nx = '0;
               end
            end
            S_RUNNING: begin
               if (bus.stop) begin
                  state_nx = S_PAUSED;
               end else if (presc == PRESC_LAST) begin
                  presc_nx = '0;
                  pulse_nx = 1'b1;
                  if (c_mt) begin
                     state_nx = S_SATURATED;
                  end else begin
                     sec_ones_nx = c_so ? 4'd0 : sec_ones + 4'd1;
                     if (c_so) sec_tens_nx = c_st ? 4'd0 : sec_tens + 4'd1;
                     if (c_st) min_ones_nx = c_mo ? 4'd0 : min_ones + 4'd1;
                     if (c_mo) min_tens_nx = min_tens + 4'd1;
                  end
               end else begin
                  presc_nx = presc + 1'b1;
               end
            end
            S_PAUSED: begin
               // Prescaler keeps its held value so the partial second survives the pause.
               if (bus.start) state_nx = S_RUNNING;
            end
            S_SATURATED: begin
               presc_nx = '0;
            end
            default: begin
               state_nx = S_IDLE;
               presc_nx = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state       <= S_IDLE;
         presc       <= '0;
         min_tens    <= 4'd0;
         min_ones    <= 4'd0;
         sec_tens    <= 4'd0;
         sec_ones    <= 4'd0;
         running_q   <= 1'b0;
         saturated_q <= 1'b0;
         sec_pulse_q <= 1'b0;
      end else begin
         state       <= state_nx;
         presc       <= presc_nx;
         min_tens    <= min_tens_nx;
         min_ones    <= min_ones_nx;
         sec_tens    <= sec_tens_nx;
         sec_ones    <= sec_ones_nx;
         running_q   <= (state_nx == S_RUNNING);
         saturated_q <= (state_nx == S_SATURATED);
         sec_pulse_q <= pulse_nx;
      end
   end

   assign bus.min_tens  = min_tens;
   assign bus.min_ones  = min_ones;
   assign bus.sec_tens  = sec_tens;
   assign bus.sec_ones  = sec_ones;
   assign bus.running   = running_q;
   assign bus.saturated = saturated_q;
   assign bus.sec_pulse = sec_pulse_q;
endmodule

// File: tb/tb_call_stopwatch.sv
// Bench for call_stopwatch: directed scenarios plus random commands, checked against an
// elapsed-seconds model of the stopwatch.
module tb_call_stopwatch;
   localparam int T = 4;
   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_SAT} mode_t;

   logic clk = 1'b0;
   logic sys_reset_n;
   call_stopwatch_if bus();

   call_stopwatch #(.TICKS_PER_SEC(T)) dut (
      .clk         (clk),
      .sys_reset_n (sys_reset_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   mode_t m_mode;
   int    m_secs, m_frac;
   logic  m_pulse;
   int    n_assert = 0, n_fail = 0;
   int    trace_err = 0, obs_pulses = 0, exp_pulses = 0;

   function automatic logic [15:0] disp();
      return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
   endfunction

   function automatic logic [15:0] exp_disp();
      int mins;
      mins = m_secs / 60;
      return {4'(mins / 10), 4'(mins % 10), 4'((m_secs % 60) / 10), 4'(m_secs % 10)};
   endfunction

   function automatic logic [18:0] dut_vec();
      return {disp(), bus.running, bus.saturated, bus.sec_pulse};
   endfunction

   function automatic logic [18:0] exp_vec();
      return {exp_disp(), m_mode == M_RUN, m_mode == M_SAT, m_pulse};
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_secs = 0; m_frac = 0; m_pulse = 1'b0;
   endtask

   // Elapsed time as an integer second count plus fraction; saturates at 5999 s.
   task automatic model_step(input logic s, input logic p, input logic c);
      m_pulse = 1'b0;
      if (c) begin
         m_mode = M_IDLE; m_secs = 0; m_frac = 0;
      end else begin
         case (m_mode)
            M_IDLE:  if (s) begin m_mode = M_RUN; m_frac = 0; end
            M_RUN: begin
               if (p) m_mode = M_PAUSE;
               else if (m_frac == T - 1) begin
                  m_frac = 0; m_pulse = 1'b1;
                  if (m_secs == 5999) m_mode = M_SAT;
                  else m_secs = m_secs + 1;
               end else m_frac = m_frac + 1;
            end
            M_PAUSE: if (s) m_mode = M_RUN;
            M_SAT:   m_frac = 0;
            default: m_mode = M_IDLE;
         endcase
      end
   endtask

   task automatic cycle(input logic s, input logic p, input logic c);
      bus.start = s; bus.stop = p; bus.clear = c;
      @(posedge clk);
      model_step(s, p, c);
      #1;
      if (dut_vec() !== exp_vec()) begin
         if (trace_err < 5)
            $display("divergence at %0t: dut %h model %h", $time, dut_vec(), exp_vec());
         trace_err++;
      end
      if (bus.sec_pulse === 1'b1) obs_pulses++;
      if (m_pulse) exp_pulses++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_trace(input string name);
      n_assert++;
      if (trace_err !== 0 || obs_pulses !== exp_pulses) begin
         n_fail++;
         $display("FAIL %s_trace: %0d divergent cycles, pulses got %0d required %0d",
                  name, trace_err, obs_pulses, exp_pulses);
      end
      trace_err = 0; obs_pulses = 0; exp_pulses = 0;
   endtask

   // Pulls reset low a few ns into a cycle, checks outputs cleared before any edge.
   task automatic reset_mid_cycle(input string name);
      bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
      #3 sys_reset_n = 1'b0;
      #1;
      model_reset();
      n_assert++;
      if (dut_vec() !== 19'd0) begin
         n_fail++;
         $display("FAIL %s_async_reset: got %h required 0", name, dut_vec());
      end
      #2 sys_reset_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
      sys_reset_n = 1'b0;
      model_reset();
      #4;
      n_assert++;
      if (dut_vec() !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_values: got %h required 0", dut_vec());
      end
      #19 sys_reset_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      n_assert++;
      if (bus.running !== 1'b1) begin
         n_fail++;
         $display("FAIL start_running: got %b required 1", bus.running);
      end
      idle(3);
      n_assert++;
      if (bus.sec_pulse !== 1'b0 || disp() !== 16'h0000) begin
         n_fail++;
         $display("FAIL early_pulse: pulse %b disp %h required 0/0000", bus.sec_pulse, disp());
      end
      idle(1);
      n_assert++;
      if (bus.sec_ones !== 4'd1 || bus.sec_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL first_second: sec_ones %0d pulse %b required 1/1", bus.sec_ones, bus.sec_pulse);
      end
      idle(36);
      n_assert++;
      if (disp() !== 16'h0010) begin
         n_fail++;
         $display("FAIL ten_seconds: got %h required 0010", disp());
      end
      reset_mid_cycle("first_count");
      check_trace("reset");
   endtask

   task automatic test_bcd_carry();
      int p0;
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      idle(236);
      n_assert++;
      if (disp() !== 16'h0059) begin
         n_fail++;
         $display("FAIL carry_0059: got %h required 0059", disp());
      end
      p0 = obs_pulses;
      idle(4);
      n_assert++;
      if (disp() !== 16'h0100 || obs_pulses - p0 !== 1 || bus.sec_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL carry_0100: got %h pulses %0d required 0100 and 1", disp(), obs_pulses - p0);
      end
      check_trace("bcd_carry");
   endtask

   task automatic test_pause();
      int p0;
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      idle(6);
      cycle(1'b0, 1'b1, 1'b0);
      n_assert++;
      if (disp() !== 16'h0001 || bus.running !== 1'b0) begin
         n_fail++;
         $display("FAIL pause_enter: disp %h running %b required 0001/0", disp(), bus.running);
      end
      p0 = obs_pulses;
      idle(20);
      n_assert++;
      if (disp() !== 16'h0001 || obs_pulses !== p0) begin
         n_fail++;
         $display("FAIL pause_hold: disp %h pulses %0d required 0001 and 0", disp(), obs_pulses - p0);
      end
      cycle(1'b1, 1'b0, 1'b0);
      idle(1);
      n_assert++;
      if (disp() !== 16'h0001) begin
         n_fail++;
         $display("FAIL resume_early: got %h required 0001", disp());
      end
      idle(1);
      n_assert++;
      if (disp() !== 16'h0002 || bus.sec_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL resume_fraction: disp %h pulse %b required 0002/1", disp(), bus.sec_pulse);
      end
      check_trace("pause");
   endtask

   task automatic test_saturation();
      int p0;
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      p0 = obs_pulses;
      idle(24000);
      n_assert++;
      if (disp() !== 16'h9959 || bus.saturated !== 1'b1 || bus.running !== 1'b0 ||
          bus.sec_pulse !== 1'b1 || obs_pulses - p0 !== 6000) begin
         n_fail++;
         $display("FAIL saturate: disp %h sat %b run %b pulse %b pulses %0d required 9959/1/0/1/6000",
                  disp(), bus.saturated, bus.running, bus.sec_pulse, obs_pulses - p0);
      end
      p0 = obs_pulses;
      for (int i = 0; i < 100; i++) cycle(1'(i % 2), 1'($urandom_range(0, 1)), 1'b0);
      n_assert++;
      if (disp() !== 16'h9959 || bus.saturated !== 1'b1 || obs_pulses !== p0) begin
         n_fail++;
         $display("FAIL saturate_hold: disp %h sat %b pulses %0d required 9959/1/0",
                  disp(), bus.saturated, obs_pulses - p0);
      end
      cycle(1'b0, 1'b0, 1'b1);
      n_assert++;
      if (dut_vec() !== 19'd0) begin
         n_fail++;
         $display("FAIL saturate_clear: got %h required 0", dut_vec());
      end
      check_trace("saturation");
   endtask

   task automatic test_priority();
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      idle(6);
      cycle(1'b1, 1'b1, 1'b1);
      n_assert++;
      if (dut_vec() !== 19'd0) begin
         n_fail++;
         $display("FAIL all_three: got %h required 0", dut_vec());
      end
      cycle(1'b1, 1'b0, 1'b0);
      idle(2);
      cycle(1'b1, 1'b1, 1'b0);
      n_assert++;
      if (bus.running !== 1'b0 || m_mode != M_PAUSE || disp() !== exp_disp()) begin
         n_fail++;
         $display("FAIL stop_over_start: running %b disp %h required 0/%h", bus.running, disp(), exp_disp());
      end
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      idle(3);
      cycle(1'b0, 1'b1, 1'b0);
      n_assert++;
      if (disp() !== 16'h0000 || bus.sec_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_on_wrap: disp %h pulse %b required 0000/0", disp(), bus.sec_pulse);
      end
      cycle(1'b1, 1'b0, 1'b0);
      idle(1);
      n_assert++;
      if (disp() !== 16'h0001 || bus.sec_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_resume: disp %h pulse %b required 0001/1", disp(), bus.sec_pulse);
      end
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      idle(3);
      cycle(1'b0, 1'b0, 1'b1);
      n_assert++;
      if (dut_vec() !== 19'd0) begin
         n_fail++;
         $display("FAIL clear_on_wrap: got %h required 0", dut_vec());
      end
      check_trace("priority");
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++)
         cycle(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 11) == 0),
               1'($urandom_range(0, 59) == 0));
      check_trace("random");
   endtask

   task automatic test_reset_mid_op();
      int guard, bad;
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      guard = 0;
      while (m_secs != 754 && guard < 4000) begin
         idle(1);
         guard++;
      end
      n_assert++;
      if (disp() !== 16'h1234 || bus.running !== 1'b1) begin
         n_fail++;
         $display("FAIL reach_1234: disp %h running %b required 1234/1", disp(), bus.running);
      end
      reset_mid_cycle("mid_op");
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         idle(1);
         if (disp() !== 16'h0000 || bus.running !== 1'b0) bad++;
      end
      n_assert++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL idle_after_reset: %0d nonzero cycles required 0", bad);
      end
      check_trace("reset_mid_op");
   endtask

   initial begin
      test_reset();
      test_bcd_carry();
      test_pause();
      test_saturation();
      test_priority();
      test_random();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
